// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Transmit scheduler for the board UART. Bytes written by the CPU I/O path
//   are queued in a circular FIFO. The scheduler pops them one at a time and
//   presents each byte on uart_txd_data with a one-cycle uart_transmit pulse.
//   It then waits for uart_txd_done, plus an optional idle gap, before it
//   starts the next byte. A watchdog aborts a byte whose done never arrives.
//
// Parameters
//   DEPTH_LOG2  FIFO depth = 2**DEPTH_LOG2 bytes
//   GAP_CYCLES  idle cycles inserted after each byte completes
//   TIMEOUT     max cycles spent waiting for done; 0 disables the watchdog
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   wr_en/wr_data  push strobe and byte from the io write decode
//   flush          drop every queued byte (a byte in flight still completes)
//   clr_flags      clear the sticky overflow/timeout_err flags
//   uart_txd_done  pulse from the transmitter: current byte finished
//   uart_txd_data  byte presented to the transmitter, held until the next pop
//   uart_transmit  one-cycle start pulse to the transmitter
//   level          bytes queued, excluding the byte in flight
//   full, empty    level == depth, level == 0
//   busy           a byte is in flight or bytes are queued
//   overflow       sticky: a write was dropped because the FIFO was full
//   timeout_err    sticky: the watchdog aborted a byte
//
// Every output is a flop. full/empty/busy are registered from the next-state
// values, so they track level and state on the same edge.

module uart_tx_sched #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                flush,
  input  logic                clr_flags,
  input  logic                uart_txd_done,
  output logic [7:0]          uart_txd_data,
  output logic                uart_transmit,
  output logic [DEPTH_LOG2:0] level,
  output logic                full,
  output logic                empty,
  output logic                busy,
  output logic                overflow,
  output logic                timeout_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // wait_cnt only needs to reach TIMEOUT-1, and gap_cnt only GAP_CYCLES-1.
  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int GCW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);

  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [WCW-1:0]      WAIT_LAST = WCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GCW-1:0]      GAP_LAST  = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit                  WDOG_EN   = (TIMEOUT > 0);
  localparam bit                  GAP_EN    = (GAP_CYCLES > 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp, rp, wp_nxt, rp_nxt;
  logic [DEPTH_LOG2:0]   level_nxt;
  logic [1:0]            state, state_nxt;
  logic [WCW-1:0]        wait_cnt, wait_nxt;
  logic [GCW-1:0]        gap_cnt, gap_nxt;
  logic [7:0]            data_nxt;
  logic                  xmit_nxt, ovf_nxt, tmo_nxt;
  logic                  push, pop, wait_exit, wdog_hit;

  always_comb begin
    state_nxt = state;
    wp_nxt    = wp;
    rp_nxt    = rp;
    level_nxt = level;
    data_nxt  = uart_txd_data;
    xmit_nxt  = 1'b0;
    wait_nxt  = wait_cnt;
    gap_nxt   = gap_cnt;
    ovf_nxt   = overflow;
    tmo_nxt   = timeout_err;
    pop       = 1'b0;
    wait_exit = 1'b0;
    wdog_hit  = 1'b0;

    // full here is the pre-edge value, so a pop on the same edge does not
    // rescue a write that arrived while the FIFO was full.
    push = wr_en && !full && !flush;

    // Clear first so a simultaneous set event overrides it.
    if (clr_flags) begin
      ovf_nxt = 1'b0;
      tmo_nxt = 1'b0;
    end
    if (wr_en && full) ovf_nxt = 1'b1;

    case (state)
      S_IDLE: begin
        if (!empty && !flush) begin
          pop       = 1'b1;
          data_nxt  = mem[rp];
          xmit_nxt  = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        wait_nxt  = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A done pulse on the watchdog's last cycle counts as a normal finish.
        wdog_hit  = WDOG_EN && (wait_cnt == WAIT_LAST) && !uart_txd_done;
        wait_exit = uart_txd_done || wdog_hit;
        if (wdog_hit) tmo_nxt = 1'b1;
        if (wait_exit) begin
          if (GAP_EN) begin
            gap_nxt   = '0;
            state_nxt = S_GAP;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
        else                     gap_nxt   = gap_cnt + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (flush) begin
      wp_nxt    = '0;
      rp_nxt    = '0;
      level_nxt = '0;
    end else begin
      if (push) wp_nxt = wp + 1'b1;
      if (pop)  rp_nxt = rp + 1'b1;
      if (push && !pop)      level_nxt = level + 1'b1;
      else if (pop && !push) level_nxt = level - 1'b1;
    end
  end

  // Storage has no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      wp            <= '0;
      rp            <= '0;
      level         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      busy          <= 1'b0;
      uart_txd_data <= 8'h00;
      uart_transmit <= 1'b0;
      wait_cnt      <= '0;
      gap_cnt       <= '0;
      overflow      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_nxt;
      wp            <= wp_nxt;
      rp            <= rp_nxt;
      level         <= level_nxt;
      full          <= (level_nxt == LVL_FULL);
      empty         <= (level_nxt == '0);
      busy          <= (state_nxt != S_IDLE) || (level_nxt != '0);
      uart_txd_data <= data_nxt;
      uart_transmit <= xmit_nxt;
      wait_cnt      <= wait_nxt;
      gap_cnt       <= gap_nxt;
      overflow      <= ovf_nxt;
      timeout_err   <= tmo_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched. Two instances share the write-side inputs:
//   dut a: depth 16, no gap, watchdog effectively off (table + directed)
//   dut b: depth 4, GAP_CYCLES=3, TIMEOUT=8 (directed + random vs model)
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_uart_tx_sched;

  logic       clk, rst;
  logic       wr_en, flush, clr_flags, done_a, done_b;
  logic [7:0] wr_data;

  logic [7:0] data_a, data_b;
  logic       xmit_a, xmit_b, full_a, full_b, empty_a, empty_b;
  logic       busy_a, busy_b, ovf_a, ovf_b, tmo_a, tmo_b;
  logic [4:0] lvl_a;
  logic [2:0] lvl_b;

  uart_tx_sched #(.DEPTH_LOG2(4), .GAP_CYCLES(0), .TIMEOUT(65535)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clr_flags(clr_flags), .uart_txd_done(done_a), .uart_txd_data(data_a),
    .uart_transmit(xmit_a), .level(lvl_a), .full(full_a), .empty(empty_a),
    .busy(busy_a), .overflow(ovf_a), .timeout_err(tmo_a));

  uart_tx_sched #(.DEPTH_LOG2(2), .GAP_CYCLES(3), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .clr_flags(clr_flags), .uart_txd_done(done_b), .uart_txd_data(data_b),
    .uart_transmit(xmit_b), .level(lvl_b), .full(full_b), .empty(empty_b),
    .busy(busy_b), .overflow(ovf_b), .timeout_err(tmo_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;
  int np_a = 0;
  int np_b = 0;

  always @(negedge clk) begin
    if (xmit_a) np_a++;
    if (xmit_b) np_b++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 0; wr_data = 0; flush = 0; clr_flags = 0; done_a = 0; done_b = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_data"},  int'(data_a), 0);
    chk({tag, "_xmit"},  int'(xmit_a), 0);
    chk({tag, "_level"}, int'(lvl_a), 0);
    chk({tag, "_full"},  int'(full_a), 0);
    chk({tag, "_empty"}, int'(empty_a), 1);
    chk({tag, "_busy"},  int'(busy_a), 0);
    chk({tag, "_ovf"},   int'(ovf_a), 0);
    chk({tag, "_tmo"},   int'(tmo_a), 0);
  endtask

  // Tick until the selected instance shows a start pulse; waited = -1 if none.
  task automatic wait_xmit(input int which, input int maxc, output int waited);
    waited = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if ((which == 0 && xmit_a) || (which == 1 && xmit_b)) begin
        waited = i;
        return;
      end
    end
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       done;
    logic [7:0] e_data;
    logic       e_x;
    int         e_lvl;
    logic       e_busy;
  } vec_t;

  vec_t tv[12];

  // Reference model state for dut b: edge-timestamped, queue-based.
  byte unsigned q_m[$];
  int  e, s_edge, next_ok, done_at, w, p0;
  bit  inflight, m_ovf, m_tmo, m_pop, full0, fin;
  byte unsigned m_data;

  initial begin
    // ---------------- table: single bytes, stray done, push+pop ----------
    tv[0]  = '{1'b1, 8'h41, 1'b0, 8'h00, 1'b0, 1, 1'b1};
    tv[1]  = '{1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 0, 1'b1};
    tv[2]  = '{1'b0, 8'h00, 1'b0, 8'h41, 1'b0, 0, 1'b1};
    tv[3]  = '{1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 0, 1'b0};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 0, 1'b0};
    tv[5]  = '{1'b1, 8'h55, 1'b0, 8'h41, 1'b0, 1, 1'b1};
    tv[6]  = '{1'b1, 8'h66, 1'b0, 8'h55, 1'b1, 1, 1'b1};
    tv[7]  = '{1'b0, 8'h00, 1'b0, 8'h55, 1'b0, 1, 1'b1};
    tv[8]  = '{1'b0, 8'h00, 1'b1, 8'h55, 1'b0, 1, 1'b1};
    tv[9]  = '{1'b0, 8'h00, 1'b0, 8'h66, 1'b1, 0, 1'b1};
    tv[10] = '{1'b0, 8'h00, 1'b0, 8'h66, 1'b0, 0, 1'b1};
    tv[11] = '{1'b0, 8'h00, 1'b1, 8'h66, 1'b0, 0, 1'b0};

    do_reset();
    check_reset_a("rst_a");
    chk("rst_b_empty", int'(empty_b), 1);
    chk("rst_b_busy", int'(busy_b), 0);
    for (int i = 0; i < 12; i++) begin
      wr_en = tv[i].wr; wr_data = tv[i].wd; done_a = tv[i].done;
      tick();
      chk($sformatf("tv%0d_data", i),  int'(data_a), int'(tv[i].e_data));
      chk($sformatf("tv%0d_xmit", i),  int'(xmit_a), int'(tv[i].e_x));
      chk($sformatf("tv%0d_level", i), int'(lvl_a), tv[i].e_lvl);
      chk($sformatf("tv%0d_full", i),  int'(full_a), int'(tv[i].e_lvl == 16));
      chk($sformatf("tv%0d_empty", i), int'(empty_a), int'(tv[i].e_lvl == 0));
      chk($sformatf("tv%0d_busy", i),  int'(busy_a), int'(tv[i].e_busy));
    end
    wr_en = 0; done_a = 0;

    // ---------------- 1: single byte, done 10 cycles after start ---------
    do_reset();
    p0 = np_a;
    wr_en = 1; wr_data = 8'h41; tick(); wr_en = 0;
    tick();
    chk("t1_xmit", int'(xmit_a), 1);
    chk("t1_data", int'(data_a), 8'h41);
    for (int i = 0; i < 9; i++) tick();
    chk("t1_busy_wait", int'(busy_a), 1);
    done_a = 1; tick(); done_a = 0;
    chk("t1_busy_done", int'(busy_a), 0);
    for (int i = 0; i < 6; i++) tick();
    chk("t1_pulses", np_a - p0, 1);

    // ---------------- 2: fill while stalled, overflow, ordered drain -----
    do_reset();
    p0 = np_a;
    wr_en = 1; wr_data = 8'hAA; tick(); wr_en = 0;
    tick(); tick();                       // 0xAA now waiting for done
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = 8'(i); tick();
    end
    chk("t2_full", int'(full_a), 1);
    chk("t2_level16", int'(lvl_a), 16);
    chk("t2_ovf_pre", int'(ovf_a), 0);
    wr_data = 8'hFF; tick();
    chk("t2_ovf", int'(ovf_a), 1);
    chk("t2_level_hold", int'(lvl_a), 16);
    clr_flags = 1; tick();                // write-while-full beats the clear
    chk("t2_ovf_setwins", int'(ovf_a), 1);
    wr_en = 0; tick(); clr_flags = 0;
    chk("t2_ovf_clr", int'(ovf_a), 0);
    done_a = 1; tick(); done_a = 0;
    for (int k = 0; k < 16; k++) begin
      wait_xmit(0, 20, w);
      chk($sformatf("t2_start%0d", k), int'(w > 0), 1);
      chk($sformatf("t2_byte%0d", k), int'(data_a), k);
      tick(); done_a = 1; tick(); done_a = 0;
    end
    for (int i = 0; i < 8; i++) tick();
    chk("t2_pulses", np_a - p0, 17);
    chk("t2_idle", int'(busy_a), 0);

    // ---------------- 3: GAP_CYCLES=3 spacing -----------------------------
    do_reset();
    p0 = np_b;
    wr_en = 1; wr_data = 8'hB1; tick();
    wr_data = 8'hB2; tick(); wr_en = 0;
    tick();                               // dut b in WAIT
    done_b = 1; tick(); done_b = 0;       // done in cycle t
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t3_gap%0d", i), int'(xmit_b), 0);
    end
    tick();
    chk("t3_xmit_t5", int'(xmit_b), 1);
    chk("t3_data", int'(data_b), 8'hB2);
    tick(); done_b = 1; tick(); done_b = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("t3_pulses", np_b - p0, 2);
    chk("t3_idle", int'(busy_b), 0);

    // ---------------- 4: watchdog TIMEOUT=8 -------------------------------
    do_reset();
    wr_en = 1; wr_data = 8'hC1; tick();
    wr_data = 8'hC2; tick(); wr_en = 0;
    tick();                               // first WAIT cycle follows
    for (int i = 0; i < 7; i++) tick();
    chk("t4_tmo_pre", int'(tmo_b), 0);
    tick();
    chk("t4_tmo", int'(tmo_b), 1);
    wait_xmit(1, 10, w);
    chk("t4_next_start", w, 4);
    chk("t4_next_data", int'(data_b), 8'hC2);
    clr_flags = 1; tick(); clr_flags = 0;
    chk("t4_clr", int'(tmo_b), 0);
    for (int i = 0; i < 7; i++) tick();
    chk("t4_tmo2_pre", int'(tmo_b), 0);
    clr_flags = 1; tick(); clr_flags = 0;
    chk("t4_tmo_setwins", int'(tmo_b), 1);
    clr_flags = 1; tick(); clr_flags = 0;
    chk("t4_clr2", int'(tmo_b), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_idle", int'(busy_b), 0);

    // ---------------- 5: flush while a byte is in flight ------------------
    do_reset();
    p0 = np_a;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 8'(8'h50 + i); tick();
    end
    wr_en = 0;
    chk("t5_level4", int'(lvl_a), 4);
    flush = 1; tick(); flush = 0;
    chk("t5_level0", int'(lvl_a), 0);
    chk("t5_empty", int'(empty_a), 1);
    chk("t5_busy_inflight", int'(busy_a), 1);
    done_a = 1; tick(); done_a = 0;
    chk("t5_busy_done", int'(busy_a), 0);
    for (int i = 0; i < 10; i++) tick();
    chk("t5_pulses", np_a - p0, 1);
    chk("t5_data_held", int'(data_a), 8'h50);

    // ---------------- 6: async reset mid-transfer -------------------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_data = 8'(8'h60 + i); tick();
    end
    wr_en = 0;
    chk("t6_level3", int'(lvl_a), 3);
    #1 rst = 1;
    #1 check_reset_a("t6_async");
    @(posedge clk);
    #1 rst = 0;
    p0 = np_a;
    done_a = 1; tick(); done_a = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_pulses", np_a - p0, 0);
    check_reset_a("t6_after");

    // ---------------- random vs reference model (dut b) -------------------
    do_reset();
    q_m.delete();
    e = 0; s_edge = 0; next_ok = 0; done_at = -1;
    inflight = 0; m_ovf = 0; m_tmo = 0; m_data = 0;
    for (int c = 0; c < 3000; c++) begin
      wr_en     = ($urandom_range(0, 9) < 4);
      wr_data   = 8'($urandom);
      flush     = ($urandom_range(0, 49) == 0);
      clr_flags = ($urandom_range(0, 24) == 0);
      done_b    = (e == done_at) || ($urandom_range(0, 59) == 0);

      // Model: a byte waits for done from two edges after its pop, or is
      // abandoned TIMEOUT edges after that; the next pop may come GAP+1
      // edges after it finishes.
      full0 = (q_m.size() == 4);
      if (clr_flags) begin m_ovf = 0; m_tmo = 0; end
      if (wr_en && full0) m_ovf = 1;
      fin = 0;
      if (inflight && e >= s_edge + 2) begin
        if (done_b) fin = 1;
        else if (e == s_edge + 1 + 8) begin fin = 1; m_tmo = 1; end
      end
      if (fin) begin inflight = 0; next_ok = e + 3 + 1; end
      m_pop = !inflight && !fin && e >= next_ok && q_m.size() != 0 && !flush;
      if (flush) q_m.delete();
      else begin
        if (m_pop) m_data = q_m.pop_front();
        if (wr_en && !full0) q_m.push_back(wr_data);
      end
      if (m_pop) begin inflight = 1; s_edge = e; end

      tick();
      chk("rnd_data",  int'(data_b), int'(m_data));
      chk("rnd_xmit",  int'(xmit_b), int'(m_pop));
      chk("rnd_level", int'(lvl_b), q_m.size());
      chk("rnd_full",  int'(full_b), int'(q_m.size() == 4));
      chk("rnd_empty", int'(empty_b), int'(q_m.size() == 0));
      chk("rnd_busy",  int'(busy_b),
          int'(inflight || (e < next_ok - 1) || q_m.size() != 0));
      chk("rnd_ovf",   int'(ovf_b), int'(m_ovf));
      chk("rnd_tmo",   int'(tmo_b), int'(m_tmo));
      if (m_pop) done_at = e + int'($urandom_range(2, 12));
      e++;
    end
    wr_en = 0; flush = 0; clr_flags = 0; done_b = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
